// File: rtl/dmi_regbus_bridge.sv
// DMI target bridging one debug request at a time onto a req/ack register bus,
// with a bus timeout so a hung slave still yields a failed DMI response.
module dmi_regbus_bridge #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmi_req_valid,
  output logic              dmi_req_ready,
  input  logic [ADDR_W-1:0] dmi_req_addr,
  input  logic [1:0]        dmi_req_op,
  input  logic [DATA_W-1:0] dmi_req_data,
  output logic              dmi_resp_valid,
  input  logic              dmi_resp_ready,
  output logic [1:0]        dmi_resp_resp,
  output logic [DATA_W-1:0] dmi_resp_data,
  output logic              rb_req,
  output logic              rb_we,
  output logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_wdata,
  input  logic              rb_ack,
  input  logic              rb_err,
  input  logic [DATA_W-1:0] rb_rdata,
  output logic              busy
);

  // Keep the counter at least one bit wide when the timeout is disabled.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e              state_q, state_d;
  logic                rb_req_q, rb_req_d;
  logic                rb_we_q, rb_we_d;
  logic [ADDR_W-1:0]   rb_addr_q, rb_addr_d;
  logic [DATA_W-1:0]   rb_wdata_q, rb_wdata_d;
  logic [1:0]          resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rb_req_q   <= 1'b0;
      rb_we_q    <= 1'b0;
      rb_addr_q  <= '0;
      rb_wdata_q <= '0;
      resp_q     <= RESP_OK;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rb_req_q   <= rb_req_d;
      rb_we_q    <= rb_we_d;
      rb_addr_q  <= rb_addr_d;
      rb_wdata_q <= rb_wdata_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rb_req_d   = rb_req_q;
    rb_we_d    = rb_we_q;
    rb_addr_d  = rb_addr_q;
    rb_wdata_d = rb_wdata_q;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (dmi_req_valid) begin
          unique case (dmi_req_op)
            2'd1, 2'd2: begin
              rb_req_d   = 1'b1;
              rb_we_d    = (dmi_req_op == 2'd2);
              rb_addr_d  = dmi_req_addr;
              rb_wdata_d = dmi_req_data;
              cnt_d      = '0;
              state_d    = BUS;
            end
            2'd0: begin
              resp_d  = RESP_OK;
              rdata_d = '0;
              state_d = RESP;
            end
            default: begin
              resp_d  = RESP_FAIL;
              rdata_d = '0;
              state_d = RESP;
            end
          endcase
        end
      end
      BUS: begin
        // Error beats ack, ack beats timeout.
        if (rb_err) begin
          resp_d   = RESP_FAIL;
          rdata_d  = '0;
          rb_req_d = 1'b0;
          state_d  = RESP;
        end else if (rb_ack) begin
          resp_d   = RESP_OK;
          rdata_d  = rb_we_q ? '0 : rb_rdata;
          rb_req_d = 1'b0;
          state_d  = RESP;
        end else if (timeout_hit) begin
          resp_d   = RESP_FAIL;
          rdata_d  = '0;
          rb_req_d = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (dmi_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmi_req_ready  = (state_q == IDLE);
  assign dmi_resp_valid = (state_q == RESP);
  assign busy           = (state_q != IDLE);
  assign dmi_resp_resp  = resp_q;
  assign dmi_resp_data  = rdata_q;
  assign rb_req         = rb_req_q;
  assign rb_we          = rb_we_q;
  assign rb_addr        = rb_addr_q;
  assign rb_wdata       = rb_wdata_q;

endmodule

// File: tb/tb_dmi_regbus_bridge.sv
// Directed scoreboard bench for dmi_regbus_bridge: main instance with the
// default timeout, plus a TIMEOUT=4 instance for the hung-slave case.
module tb_dmi_regbus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmi_req_valid, dmi_resp_ready, rb_ack, rb_err;
  logic [6:0]  dmi_req_addr;
  logic [1:0]  dmi_req_op;
  logic [31:0] dmi_req_data, rb_rdata;
  logic        dmi_req_ready, dmi_resp_valid, rb_req, rb_we, busy;
  logic [1:0]  dmi_resp_resp;
  logic [31:0] dmi_resp_data, rb_wdata;
  logic [6:0]  rb_addr;

  logic        t_req_valid, t_resp_ready, t_ack, t_err;
  logic        t_req_ready, t_resp_valid, t_rb_req, t_rb_we, t_busy;
  logic [1:0]  t_resp;
  logic [31:0] t_resp_data, t_rb_wdata;
  logic [6:0]  t_rb_addr;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dmi_regbus_bridge dut (
    .clk(clk), .reset(reset),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_op(dmi_req_op), .dmi_req_data(dmi_req_data),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
    .dmi_resp_resp(dmi_resp_resp), .dmi_resp_data(dmi_resp_data),
    .rb_req(rb_req), .rb_we(rb_we), .rb_addr(rb_addr), .rb_wdata(rb_wdata),
    .rb_ack(rb_ack), .rb_err(rb_err), .rb_rdata(rb_rdata), .busy(busy)
  );

  dmi_regbus_bridge #(.TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset),
    .dmi_req_valid(t_req_valid), .dmi_req_ready(t_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_op(dmi_req_op), .dmi_req_data(dmi_req_data),
    .dmi_resp_valid(t_resp_valid), .dmi_resp_ready(t_resp_ready),
    .dmi_resp_resp(t_resp), .dmi_resp_data(t_resp_data),
    .rb_req(t_rb_req), .rb_we(t_rb_we), .rb_addr(t_rb_addr), .rb_wdata(t_rb_wdata),
    .rb_ack(t_ack), .rb_err(t_err), .rb_rdata(rb_rdata), .busy(t_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge and record its expected response.
  task automatic send(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                      input logic [1:0] eresp, input logic [31:0] edata);
    check("req_ready_before_fire", 64'(dmi_req_ready), 64'd1);
    dmi_req_valid = 1'b1;
    dmi_req_op    = op;
    dmi_req_addr  = addr;
    dmi_req_data  = data;
    sb.push_back('{resp: eresp, data: edata});
    step();
    dmi_req_valid = 1'b0;
    dmi_req_op    = 2'd0;
  endtask

  // Wait (bounded) for a response, score it, then handshake it away.
  task automatic get_resp(input int bound);
    exp_t e;
    int   n;
    n = 0;
    while (!dmi_resp_valid && n < bound) begin
      step();
      n++;
    end
    if (!dmi_resp_valid) begin
      check("resp_wait_timeout", 64'd0, 64'd1);
    end else if (sb.size() == 0) begin
      check("unexpected_resp", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check("resp_code", 64'(dmi_resp_resp), 64'(e.resp));
      check("resp_data", 64'(dmi_resp_data), 64'(e.data));
    end
    dmi_resp_ready = 1'b1;
    step();
    dmi_resp_ready = 1'b0;
    check("resp_valid_after_hs", 64'(dmi_resp_valid), 64'd0);
    check("req_ready_after_hs", 64'(dmi_req_ready), 64'd1);
  endtask

  initial begin
    int cnt;
    reset = 1'b0;
    dmi_req_valid = 1'b0; dmi_req_op = 2'd0; dmi_req_addr = '0; dmi_req_data = '0;
    dmi_resp_ready = 1'b0; rb_ack = 1'b0; rb_err = 1'b0; rb_rdata = '0;
    t_req_valid = 1'b0; t_resp_ready = 1'b0; t_ack = 1'b0; t_err = 1'b0;
    step();
    step();
    check("rst_resp_valid", 64'(dmi_resp_valid), 64'd0);
    check("rst_rb_req", 64'(rb_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rb_addr", 64'(rb_addr), 64'd0);
    check("rst_resp_data", 64'(dmi_resp_data), 64'd0);
    reset = 1'b1;
    step();
    check("rst_req_ready", 64'(dmi_req_ready), 64'd1);

    // Ack outside BUS is ignored.
    rb_ack = 1'b1; rb_rdata = 32'h5555_AAAA;
    step();
    rb_ack = 1'b0;
    check("idle_ack_ignored", {62'd0, busy, dmi_resp_valid}, 64'd0);

    // Read, slave acks in the cycle after rb_req rises.
    send(2'd1, 7'h10, 32'h0, 2'd0, 32'hDEAD_BEEF);
    check("rd_rb_req", 64'(rb_req), 64'd1);
    check("rd_rb_we", 64'(rb_we), 64'd0);
    check("rd_rb_addr", 64'(rb_addr), 64'h10);
    check("rd_busy", 64'(busy), 64'd1);
    check("rd_no_early_resp", 64'(dmi_resp_valid), 64'd0);
    rb_ack = 1'b1; rb_rdata = 32'hDEAD_BEEF;
    step();
    rb_ack = 1'b0; rb_rdata = 32'h0;
    check("rd_rb_req_drop", 64'(rb_req), 64'd0);
    check("rd_latency", 64'(dmi_resp_valid), 64'd1);
    get_resp(1);

    // Write, slave acks after 5 cycles of rb_req.
    send(2'd2, 7'h04, 32'h1234_5678, 2'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("wr_hold", {rb_req, rb_we, 7'(rb_addr), rb_wdata}, {1'b1, 1'b1, 7'h04, 32'h1234_5678});
      check("wr_req_ready_low", 64'(dmi_req_ready), 64'd0);
      if (i == 4) begin
        rb_ack = 1'b1; rb_rdata = 32'hFFFF_FFFF;
      end
      step();
    end
    rb_ack = 1'b0; rb_rdata = 32'h0;
    get_resp(2);

    // Error and ack in the same cycle: error wins.
    send(2'd1, 7'h08, 32'h0, 2'd2, 32'h0);
    rb_ack = 1'b1; rb_err = 1'b1; rb_rdata = 32'hAAAA_5555;
    step();
    rb_ack = 1'b0; rb_err = 1'b0; rb_rdata = 32'h0;
    get_resp(2);

    // Hung slave on the TIMEOUT=4 instance.
    dmi_req_op = 2'd1; dmi_req_addr = 7'h22; t_req_valid = 1'b1;
    step();
    t_req_valid = 1'b0; dmi_req_op = 2'd0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!t_rb_req) break;
      cnt++;
      step();
    end
    check("to_req_cycles", 64'(cnt), 64'd4);
    check("to_resp_valid", 64'(t_resp_valid), 64'd1);
    check("to_resp_code", 64'(t_resp), 64'd2);
    check("to_resp_data", 64'(t_resp_data), 64'd0);
    t_resp_ready = 1'b1;
    step();
    t_resp_ready = 1'b0;
    check("to_back_idle", 64'(t_req_ready), 64'd1);

    // Nop completes on the fire edge without touching the bus.
    send(2'd0, 7'h01, 32'h0, 2'd0, 32'h0);
    check("nop_latency", 64'(dmi_resp_valid), 64'd1);
    check("nop_no_rb_req", 64'(rb_req), 64'd0);
    get_resp(1);

    // Reserved op with response backpressure; a stray request is ignored.
    send(2'd3, 7'h02, 32'h0, 2'd2, 32'h0);
    dmi_req_valid = 1'b1; dmi_req_op = 2'd1;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", {dmi_resp_valid, dmi_req_ready, rb_req, dmi_resp_resp, dmi_resp_data},
            {1'b1, 1'b0, 1'b0, 2'd2, 32'h0});
      step();
    end
    dmi_req_valid = 1'b0; dmi_req_op = 2'd0;
    get_resp(1);

    // Reset mid-transaction, asserted between clock edges.
    send(2'd1, 7'h30, 32'h0, 2'd0, 32'h0);
    check("rst_mid_in_bus", 64'(rb_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_async", {61'd0, rb_req, busy, dmi_resp_valid}, 64'd0);
    sb.delete();
    step();
    reset = 1'b1;
    step();
    check("rst_mid_ready", 64'(dmi_req_ready), 64'd1);
    check("rst_mid_addr", 64'(rb_addr), 64'd0);
    send(2'd1, 7'h11, 32'h0, 2'd0, 32'hCAFE_F00D);
    rb_ack = 1'b1; rb_rdata = 32'hCAFE_F00D;
    step();
    rb_ack = 1'b0; rb_rdata = 32'h0;
    get_resp(2);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
